s2c_call_arb: RTL
=================

// Module: s2c_call_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one s2cif function-call channel among NREQ
//  stimulus drivers (dff-style drivers each needing one data word per clock edge).
//  Serialises requests, issues one call at a time with the requester's id/fn, routes
//  ret/data back to the winner only, and converts hung calls into an error return.
// PARAMETERS
//  NREQ    4    number of requesters (2..16)
//  DW      32   payload data width (matches pkt data[0])
//  FNW     8    function-number width
//  TMO     1024 cycles a call may stay outstanding before forced error return
// PORTS
//  clk         in   1         clock
//  rst         in   1         reset, asynchronous, active-high
//  req         in   NREQ      per-requester call request, level, held until rsp_vld
//  req_fn      in   NREQ*FNW  per-requester function number, slice i = requester i
//  rsp_vld     out  NREQ      one-hot one-cycle response strobe to granted requester
//  rsp_ret     out  32        return code (0 data, 1 data end, 2 timeout, other = callee)
//  rsp_data    out  DW        returned data, valid with rsp_vld
//  call_vld    out  1         call issued to channel bridge
//  call_id     out  8         requester index (= driver id) of current call
//  call_fn     out  FNW       function number of current call
//  call_rdy    in   1         bridge accepts call (call_vld & call_rdy = issue)
//  done_vld    in   1         bridge completion strobe, one cycle
//  done_ret    in   32        completion return code
//  done_data   in   DW        completion data
//  busy        out  1         high in any state other than IDLE
//  tmo_err     out  1         sticky, set on any timeout, cleared only by rst
// BEHAVIOUR
//  Reset: state IDLE, rsp_vld=0, rsp_ret=0, rsp_data=0, call_vld=0, call_id=0,
//   call_fn=0, busy=0, tmo_err=0, rr pointer=0, timeout counter=0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if any req, grant first set bit at or after rr pointer (wrapping NREQ-1->0);
//    latch grant index, call_id, call_fn; go ISSUE next cycle. No req: stay.
//   ISSUE: call_vld=1, id/fn stable; on call_rdy -> WAIT, clear counter. call_vld may
//    stay high any number of cycles; counter runs in ISSUE too (timeout applies).
//   WAIT: count cycles; on done_vld capture done_ret/done_data -> RESP.
//    Counter reaching TMO-1 without done_vld: ret=2, data=0, set tmo_err -> RESP.
//   RESP: rsp_vld[grant]=1 for exactly one cycle with captured ret/data; rr pointer
//    = grant+1 mod NREQ; -> IDLE. Minimum req-to-rsp latency: 3 cycles + bridge latency.
//  done_vld outside WAIT (incl. late completion after timeout) is ignored.
//  done_vld in same cycle as timeout expiry: done wins, no error.
//  Requester dropping req while granted: call still completes; response still pulsed.
//  A requester is not re-granted before all other pending requesters are served.
//  req sampled in IDLE only; grant fixed until RESP.
//  rst mid-call: immediate return to reset state; in-flight completion discarded.
//  rsp_ret/rsp_data hold last value outside rsp_vld.
// STRUCTURE
//  Shared package s2c_pkg: state enum {IDLE,ISSUE,WAIT,RESP}; return-code constants
//   RET_DATA=0, RET_END=1, RET_TMO=2; uint32 typedef.
//  Sub-module rr_pick (NREQ, combinational): req vector + pointer -> one-hot grant,
//   index, any. Timeout counter width $clog2(TMO)+1, inline.
// TESTING
//  Single req[1], fn=0, bridge rdy same cycle, done after 2 cycles ret=0 data=0x1 ->
//   rsp_vld=0b0010 one cycle, rsp_ret=0, rsp_data=0x1, call_id=1.
//  req=0b1111 held, all done ret=0 -> grant order 0,1,2,3,0; never two rsp_vld bits.
//  Bridge never asserts done_vld, TMO=16 -> rsp_ret=2, rsp_data=0 after 16 WAIT cycles,
//   tmo_err=1; a later stray done_vld produces no rsp_vld.
//  done_vld with ret=1 -> rsp_ret=1 passed unchanged; call_rdy low 5 cycles -> call_vld
//   held with stable id/fn, no issue until rdy.
//  Assert rst during WAIT -> all outputs reset values next edge, pending done ignored.

Source files
------------

// File: rtl/s2c_pkg.sv
// Shared types and constants for the s2c function-call arbiter.
// Pure declarations, no logic.
// No flow control of its own.
package s2c_pkg;

    // Sequencer states: one call in flight at a time
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic [31:0] uint32;

    // Return codes seen by requesters; anything else comes from the callee
    localparam uint32 RET_DATA = 32'd0;
    localparam uint32 RET_END  = 32'd1;
    localparam uint32 RET_TMO  = 32'd2;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to consume the grant.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    // Candidate index ptr+k, kept one bit wider so the wrap compare cannot overflow
    logic [IW:0]   cand;
    logic [IW-1:0] cidx;

    // Scan outward from the pointer; the first hit wins and later hits are ignored
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        cidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            cidx = cand[IW-1:0];
            if (!any_o && req_i[cidx]) begin
                any_o = 1'b1;
                idx_o = cidx;
                gnt_o = NREQ'(1) << cidx;
            end
        end
    end

endmodule

// File: rtl/s2c_call_arb.sv
// Shares one s2cif call channel among NREQ drivers, one call in flight at a time.
// Latency: req to rsp_vld is 3 cycles plus bridge accept/complete time; hung calls end after TMO cycles.
// Backpressure: call_vld holds with stable id/fn until call_rdy; requesters hold req until their rsp_vld.
module s2c_call_arb
    import s2c_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int FNW  = 8,
    parameter int TMO  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*FNW-1:0] req_fn_i,
    output logic [NREQ-1:0]   rsp_vld_o,
    output uint32             rsp_ret_o,
    output logic [DW-1:0]     rsp_data_o,
    output logic              call_vld_o,
    output logic [7:0]        call_id_o,
    output logic [FNW-1:0]    call_fn_o,
    input  logic              call_rdy_i,
    input  logic              done_vld_i,
    input  uint32             done_ret_i,
    input  logic [DW-1:0]     done_data_i,
    output logic              busy_o,
    output logic              tmo_err_o
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO) + 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [7:0]      call_id_q, call_id_d;
    logic [FNW-1:0]  call_fn_q, call_fn_d;
    uint32           ret_q, ret_d;
    logic [DW-1:0]   data_q, data_d;
    logic            tmo_err_q, tmo_err_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [FNW-1:0]  pick_fn;
    logic            tmo_hit;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Function number of the requester the picker selected
    always_comb begin
        pick_fn = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                pick_fn = req_fn_i[i*FNW +: FNW];
            end
        end
    end

    // The same counter guards both the accept wait and the completion wait
    assign tmo_hit = (cnt_q == CW'(TMO - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a real completion beats an expiry landing in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = ISSUE;
            ISSUE:   if (call_rdy_i) state_d = WAIT;
                     else if (tmo_hit) state_d = RESP;
            WAIT:    if (done_vld_i || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: grant latch, timeout count, response capture, pointer advance
    always_comb begin
        cnt_d     = cnt_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        call_id_d = call_id_q;
        call_fn_d = call_fn_q;
        ret_d     = ret_q;
        data_d    = data_q;
        tmo_err_d = tmo_err_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gidx_d    = pick_idx;
                    call_id_d = 8'(pick_idx);
                    call_fn_d = pick_fn;
                    cnt_d     = '0;
                end
            end
            ISSUE: begin
                if (call_rdy_i) begin
                    cnt_d = '0;
                end else if (tmo_hit) begin
                    ret_d     = RET_TMO;
                    data_d    = '0;
                    tmo_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                if (done_vld_i) begin
                    ret_d  = done_ret_i;
                    data_d = done_data_i;
                end else if (tmo_hit) begin
                    ret_d     = RET_TMO;
                    data_d    = '0;
                    tmo_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any call in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            call_id_q <= '0;
            call_fn_q <= '0;
            ret_q     <= '0;
            data_q    <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            call_id_q <= call_id_d;
            call_fn_q <= call_fn_d;
            ret_q     <= ret_d;
            data_q    <= data_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    // Outputs decoded from state; the response strobe goes only to the granted requester
    always_comb begin
        rsp_vld_o  = '0;
        call_vld_o = 1'b0;
        busy_o     = (state_q != IDLE);
        if (state_q == RESP) begin
            rsp_vld_o = NREQ'(1) << gidx_q;
        end
        if (state_q == ISSUE) begin
            call_vld_o = 1'b1;
        end
    end

    assign call_id_o  = call_id_q;
    assign call_fn_o  = call_fn_q;
    assign rsp_ret_o  = ret_q;
    assign rsp_data_o = data_q;
    assign tmo_err_o  = tmo_err_q;

endmodule
